// File: rtl/cond_ctrl_if.sv
// Control-side bundle between the multicycle controller and the datapath/memory.
// The controller drives the selects and strobes; opcode and memReady come back in.
interface cond_ctrl_if #(parameter int OP_W = 4);
   logic [OP_W-1:0] op;
   logic            memReady;
   logic            memReq;
   logic            IRWrite;
   logic            AdrSrc;
   logic            ALUSrcB;
   logic [1:0]      ALUOp;
   logic            ResultSrc;
   logic            flagUpdate;
   logic            PCS;
   logic            regW;
   logic            memWriteSrc;
   logic            PCWrite;
   logic            illegal;
   logic            memTimeout;

   modport master (
      input  op, memReady,
      output memReq, IRWrite, AdrSrc, ALUSrcB, ALUOp, ResultSrc, flagUpdate,
             PCS, regW, memWriteSrc, PCWrite, illegal, memTimeout
   );

   modport slave (
      output op, memReady,
      input  memReq, IRWrite, AdrSrc, ALUSrcB, ALUOp, ResultSrc, flagUpdate,
             PCS, regW, memWriteSrc, PCWrite, illegal, memTimeout
   );
endinterface

// File: rtl/cond_ctrl_fsm.sv
// Multicycle fetch/decode/execute controller producing the strobes consumed by condLogic,
// with a saturating memory-wait watchdog that aborts stalled accesses back to FETCH.
module cond_ctrl_fsm #(
   parameter int OP_W    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   cond_ctrl_if.master   bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4);
   localparam logic [OP_W-1:0] OP_CMP  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_LDR  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_STR  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_B    = OP_W'(8);
   localparam logic [OP_W-1:0] OP_NOP  = OP_W'(15);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC, ALUWB, CMPF, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
   } state_t;

   state_t          state, nextState;
   logic            active;
   logic [CNT_W-1:0] waitCnt, nextCnt;
   logic [OP_W-1:0] opReg;
   logic            waitState, done, timeoutHit;

   // active holds every output low until the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         active  <= 1'b0;
         waitCnt <= '0;
         opReg   <= '0;
      end else begin
         state   <= nextState;
         active  <= 1'b1;
         waitCnt <= nextCnt;
         if (state == DECODE) opReg <= bus.op;
      end
   end

   assign waitState  = active && (state == FETCH || state == MEMRD || state == MEMWR);
   assign done       = waitState && bus.memReady;
   assign timeoutHit = waitState && !bus.memReady && (waitCnt == CNT_W'(TIMEOUT));

   always_comb begin
      nextState       = state;
      bus.memReq      = waitState && !timeoutHit;
      bus.IRWrite     = 1'b0;
      bus.AdrSrc      = 1'b0;
      bus.ALUSrcB     = 1'b0;
      bus.ALUOp       = 2'b00;
      bus.ResultSrc   = 1'b0;
      bus.flagUpdate  = 1'b0;
      bus.PCS         = 1'b0;
      bus.regW        = 1'b0;
      bus.memWriteSrc = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.illegal     = 1'b0;
      bus.memTimeout  = timeoutHit;

      case (state)
         FETCH: begin
            if (done) begin
               bus.IRWrite = 1'b1;
               bus.PCWrite = 1'b1;
               nextState   = DECODE;
            end
         end
         DECODE: begin
            case (bus.op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: nextState = EXEC;
               OP_CMP:          nextState = CMPF;
               OP_LDR, OP_STR:  nextState = MEMADR;
               OP_B:            nextState = BRANCH;
               OP_NOP:          nextState = FETCH;
               default: begin
                  bus.illegal = 1'b1;
                  nextState   = FETCH;
               end
            endcase
         end
         // ALU control comes from the opcode latched in DECODE, not the live IR field
         EXEC: begin
            case (opReg)
               OP_SUB:  bus.ALUOp = 2'b01;
               OP_AND:  bus.ALUOp = 2'b10;
               OP_OR:   bus.ALUOp = 2'b11;
               OP_ADDI: bus.ALUSrcB = 1'b1;
               default: bus.ALUOp = 2'b00;
            endcase
            nextState = ALUWB;
         end
         ALUWB: begin
            bus.regW  = 1'b1;
            nextState = FETCH;
         end
         CMPF: begin
            bus.ALUOp      = 2'b01;
            bus.flagUpdate = 1'b1;
            nextState      = FETCH;
         end
         MEMADR: begin
            bus.ALUSrcB = 1'b1;
            nextState   = (opReg == OP_STR) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.AdrSrc = 1'b1;
            if (done)            nextState = MEMWB;
            else if (timeoutHit) nextState = FETCH;
         end
         MEMWB: begin
            bus.regW      = 1'b1;
            bus.ResultSrc = 1'b1;
            nextState     = FETCH;
         end
         MEMWR: begin
            bus.AdrSrc      = 1'b1;
            bus.memWriteSrc = !timeoutHit;
            if (done || timeoutHit) nextState = FETCH;
         end
         BRANCH: begin
            bus.PCS   = 1'b1;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
   end

   // Wait counter restarts on every state change, completion or abort and saturates
   always_comb begin
      nextCnt = waitCnt;
      if (nextState != state || done || timeoutHit)
         nextCnt = '0;
      else if (bus.memReq && !bus.memReady && waitCnt != CNT_W'(TIMEOUT))
         nextCnt = waitCnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_cond_ctrl_fsm.sv
// Bench for cond_ctrl_fsm: per-cycle vector table fed through an expected-output queue,
// plus hand sequences for reset behaviour.
module tb_cond_ctrl_fsm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cond_ctrl_if #(.OP_W(4)) bus();

   cond_ctrl_fsm #(.OP_W(4), .TIMEOUT(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // {memReq,IRWrite,AdrSrc,ALUSrcB,ALUOp[1:0],ResultSrc,flagUpdate,PCS,regW,memWriteSrc,PCWrite,illegal,memTimeout}
   logic [13:0] obs;
   assign obs = {bus.memReq, bus.IRWrite, bus.AdrSrc, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc,
                 bus.flagUpdate, bus.PCS, bus.regW, bus.memWriteSrc, bus.PCWrite,
                 bus.illegal, bus.memTimeout};

   localparam logic [13:0] NONE  = 14'h0000;
   localparam logic [13:0] FWAIT = 14'h2000;
   localparam logic [13:0] FDONE = 14'h3004;
   localparam logic [13:0] ILL   = 14'h0002;
   localparam logic [13:0] EADD  = 14'h0000;
   localparam logic [13:0] ESUB  = 14'h0100;
   localparam logic [13:0] EAND  = 14'h0200;
   localparam logic [13:0] EOR   = 14'h0300;
   localparam logic [13:0] EADDI = 14'h0400;
   localparam logic [13:0] AWB   = 14'h0010;
   localparam logic [13:0] CMPF  = 14'h0140;
   localparam logic [13:0] MADR  = 14'h0400;
   localparam logic [13:0] MRD   = 14'h2800;
   localparam logic [13:0] MWB   = 14'h0090;
   localparam logic [13:0] MWR   = 14'h2808;
   localparam logic [13:0] BR    = 14'h0020;
   localparam logic [13:0] TOUT  = 14'h0801;
   localparam logic [3:0]  X     = 4'hA;

   typedef struct {
      logic [3:0]  op;
      logic        rdy;
      logic [13:0] exp;
      string       tag;
   } vec_t;

   vec_t        vecs[$];
   logic [13:0] sbExp[$];
   string       sbTag[$];
   int          applied = 0;
   int          miscompares = 0;

   task automatic addVec(input logic [3:0] op, input logic rdy, input logic [13:0] exp,
                         input string tag);
      vec_t v;
      v.op = op; v.rdy = rdy; v.exp = exp; v.tag = tag;
      vecs.push_back(v);
   endtask

   task automatic compare(input string tag, input logic [13:0] act, input logic [13:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: outputs got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      bus.op       = v.op;
      bus.memReady = v.rdy;
      sbExp.push_back(v.exp);
      sbTag.push_back(v.tag);
   endtask

   task automatic checkOutput();
      logic [13:0] e;
      string       t;
      @(negedge clk);
      e = sbExp.pop_front();
      t = sbTag.pop_front();
      compare(t, obs, e);
   endtask

   task automatic buildTable();
      logic [3:0]  aluOps [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      logic [13:0] aluExp [5] = '{EADD, ESUB, EAND, EOR, EADDI};
      for (int i = 0; i < 5; i++) begin
         addVec(X, 1'b1, FDONE, "alu_fetch");
         addVec(aluOps[i], 1'b0, NONE, "alu_decode");
         addVec(4'hF, 1'b0, aluExp[i], "alu_exec");
         addVec(X, 1'b1, AWB, "alu_wb");
      end
      addVec(X, 1'b0, FWAIT, "cmp_fetch_wait");
      addVec(X, 1'b0, FWAIT, "cmp_fetch_wait");
      addVec(X, 1'b1, FDONE, "cmp_fetch");
      addVec(4'd5, 1'b1, NONE, "cmp_decode");
      addVec(X, 1'b0, CMPF, "cmp_flag");
      addVec(X, 1'b1, FDONE, "b_fetch");
      addVec(4'd8, 1'b0, NONE, "b_decode");
      addVec(X, 1'b0, BR, "b_branch");
      addVec(X, 1'b1, FDONE, "nop_fetch");
      addVec(4'hF, 1'b0, NONE, "nop_decode");
      addVec(X, 1'b1, FDONE, "ill_fetch");
      addVec(4'd9, 1'b0, ILL, "illegal_decode");
      addVec(X, 1'b1, FDONE, "ldr_fetch");
      addVec(4'd6, 1'b1, NONE, "ldr_decode");
      addVec(X, 1'b1, MADR, "ldr_memadr");
      addVec(X, 1'b1, MRD, "ldr_read");
      addVec(X, 1'b0, MWB, "ldr_wb");
      addVec(X, 1'b1, FDONE, "str_fetch");
      addVec(4'd7, 1'b0, NONE, "str_decode");
      addVec(X, 1'b0, MADR, "str_memadr");
      for (int i = 0; i < 3; i++) addVec(X, 1'b0, MWR, "str_wait");
      addVec(X, 1'b1, MWR, "str_done");
      addVec(X, 1'b1, FDONE, "to_fetch");
      addVec(4'd6, 1'b0, NONE, "to_decode");
      addVec(X, 1'b0, MADR, "to_memadr");
      for (int i = 0; i < 15; i++) addVec(X, 1'b0, MRD, "to_wait");
      addVec(X, 1'b0, TOUT, "to_timeout");
      addVec(X, 1'b0, FWAIT, "to_refetch");
      addVec(X, 1'b1, FDONE, "late_fetch");
      addVec(4'd6, 1'b0, NONE, "late_decode");
      addVec(X, 1'b0, MADR, "late_memadr");
      for (int i = 0; i < 15; i++) addVec(X, 1'b0, MRD, "late_wait");
      addVec(X, 1'b1, MRD, "late_ready_wins");
      addVec(X, 1'b0, MWB, "late_wb");
      addVec(X, 1'b1, FDONE, "rst_fetch");
      addVec(4'd7, 1'b0, NONE, "rst_decode");
      addVec(X, 1'b0, MADR, "rst_memadr");
      addVec(X, 1'b0, MWR, "rst_memwr");
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      bus.op       = 4'd0;
      bus.memReady = 1'b1;
      buildTable();

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compare("reset_hold", obs, NONE);
      end

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sbExp.push_back(NONE);
      sbTag.push_back("release_cycle");
      checkOutput();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      // Reset dropped in the middle of the MEMWR cycle must clear strobes without a clock
      #1;
      rst_n = 1'b0;
      #1;
      compare("async_reset_memwr", obs, NONE);
      @(negedge clk);
      compare("reset_held", obs, NONE);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sbExp.push_back(NONE);
      sbTag.push_back("rerelease_cycle");
      checkOutput();

      v.op = X; v.rdy = 1'b0; v.exp = FWAIT; v.tag = "post_reset_fetch";
      applyStimulus(v);
      checkOutput();
      v.rdy = 1'b1; v.exp = FDONE; v.tag = "post_reset_fetch_done";
      applyStimulus(v);
      checkOutput();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
